// File: rtl/wash_timer.sv
// wash_timer: phase-duration timer for the washing-machine controller.
// Tracks the current wash phase, counts its programmed duration in minutes
// (TICKS_PER_MIN clk_fsm cycles each), and returns a one-cycle timer_finish
// pulse when the phase duration has elapsed.
// Optional feature macro: WASH_TIMER_PAUSE_EN adds a pause input that freezes
// counting (lid open). The default build has no pause port.
module wash_timer #(
  parameter int unsigned TICKS_PER_MIN = 3000,
  parameter int unsigned FILL_MIN      = 1,
  parameter int unsigned WASH_MIN      = 5,
  parameter int unsigned RINSE_MIN     = 2,
  parameter int unsigned SPIN_MIN      = 1
) (
  input  logic       clk_fsm,
  input  logic       rst_n,
  input  logic       state_time,
  input  logic       double_time,
  input  logic       wash_done,
`ifdef WASH_TIMER_PAUSE_EN
  input  logic       pause,
`endif
  output logic       timer_finish,
  output logic [2:0] phase,
  output logic [7:0] min_left,
  output logic       busy
);

  typedef enum logic [2:0] {
    PH_IDLE  = 3'd0,
    PH_FILL  = 3'd1,
    PH_WASH  = 3'd2,
    PH_RINSE = 3'd3,
    PH_SPIN  = 3'd4
  } phase_e;

  // Prescaler counts TICKS_PER_MIN-1 down to 0; TICKS_PER_MIN >= 2 keeps PW >= 1.
  localparam int unsigned    PW        = $clog2(TICKS_PER_MIN);
  localparam logic [PW-1:0]  PRESC_MAX = PW'(TICKS_PER_MIN - 1);

  // Phase durations are truncated to the 8-bit minute counter.
  localparam logic [7:0] FILL_DUR  = 8'(FILL_MIN);
  localparam logic [7:0] WASH_DUR  = 8'(WASH_MIN);
  localparam logic [7:0] RINSE_DUR = 8'(RINSE_MIN);
  localparam logic [7:0] SPIN_DUR  = 8'(SPIN_MIN);

  phase_e        phase_q;
  phase_e        phase_d;
  logic [7:0]    min_left_q;
  logic [7:0]    load_min_d;
  logic [PW-1:0] presc_q;
  logic          finish_q;
  logic          run_en;

`ifdef WASH_TIMER_PAUSE_EN
  assign run_en = ~pause;
`else
  assign run_en = 1'b1;
`endif

  // Phase a state_time strobe would advance to, and that phase's duration.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    phase_d    = phase_q;
    load_min_d = 8'd0;
    case (phase_q)
      PH_IDLE:  phase_d = PH_FILL;
      PH_FILL:  phase_d = PH_WASH;
      PH_WASH:  phase_d = PH_RINSE;
      PH_RINSE: phase_d = double_time ? PH_WASH : PH_SPIN;
      PH_SPIN:  phase_d = PH_SPIN;
      default:  phase_d = PH_IDLE;
    endcase
    case (phase_d)
      PH_FILL:  load_min_d = FILL_DUR;
      PH_WASH:  load_min_d = WASH_DUR;
      PH_RINSE: load_min_d = RINSE_DUR;
      PH_SPIN:  load_min_d = SPIN_DUR;
      default:  load_min_d = 8'd0;
    endcase
  end

  // Phase FSM, minute counter, prescaler and the registered finish pulse.
  always_ff @(posedge clk_fsm or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_IDLE;
      min_left_q <= 8'd0;
      presc_q    <= '0;
      finish_q   <= 1'b0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples
      // pre-edge values, independent of statement order.
      finish_q <= 1'b0;
      if (wash_done) begin
        // Completion wins over a simultaneous load and never pulses finish.
        phase_q    <= PH_IDLE;
        min_left_q <= 8'd0;
        presc_q    <= '0;
      end else if (state_time) begin
        // Advance discards any pending count and starts a full first minute.
        phase_q    <= phase_d;
        min_left_q <= load_min_d;
        presc_q    <= PRESC_MAX;
      end else if (phase_q != PH_IDLE && min_left_q != 8'd0 && run_en) begin
        if (presc_q != '0) begin
          presc_q <= presc_q - PW'(1);
        end else begin
          presc_q    <= PRESC_MAX;
          min_left_q <= min_left_q - 8'd1;
          if (min_left_q == 8'd1) begin
            finish_q <= 1'b1;
          end
        end
      end
    end
  end

  assign timer_finish = finish_q;
  assign phase        = phase_q;
  assign min_left     = min_left_q;
  assign busy         = (phase_q != PH_IDLE);

endmodule

// File: tb/tb_wash_timer.sv
// tb_wash_timer: directed stimulus for wash_timer with a tick-level reference
// model (remaining ticks per phase, minutes derived by rounding up) compared
// against the DUT on every falling edge, plus literal expectations.
module tb_wash_timer;

  localparam int T     = 4;
  localparam int FILL  = 1;
  localparam int WASH  = 2;
  localparam int RINSE = 1;
  localparam int SPIN  = 1;

  logic       clk_fsm     = 1'b0;
  logic       rst_n       = 1'b0;
  logic       state_time  = 1'b0;
  logic       double_time = 1'b0;
  logic       wash_done   = 1'b0;
  logic       pause       = 1'b0;
  logic       timer_finish;
  logic [2:0] phase;
  logic [7:0] min_left;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;
  bit cmp_en      = 1'b0;

  always #5 clk_fsm = ~clk_fsm;

  wash_timer #(
    .TICKS_PER_MIN(T),
    .FILL_MIN     (FILL),
    .WASH_MIN     (WASH),
    .RINSE_MIN    (RINSE),
    .SPIN_MIN     (SPIN)
  ) dut (
    .clk_fsm     (clk_fsm),
    .rst_n       (rst_n),
    .state_time  (state_time),
    .double_time (double_time),
    .wash_done   (wash_done),
`ifdef WASH_TIMER_PAUSE_EN
    .pause       (pause),
`endif
    .timer_finish(timer_finish),
    .phase       (phase),
    .min_left    (min_left),
    .busy        (busy)
  );

  // ---------------- reference model ----------------
  int dur_tab [5] = '{0, FILL, WASH, RINSE, SPIN};
  int m_phase = 0;
  int m_rem   = 0;   // clock ticks left in the current phase
  bit m_fin   = 1'b0;

  function automatic int next_phase(input int p, input logic dbl);
    case (p)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      3:       return dbl ? 2 : 4;
      default: return 4;
    endcase
  endfunction

  always @(posedge clk_fsm or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_rem   <= 0;
      m_fin   <= 1'b0;
    end else begin
      m_fin <= 1'b0;
      if (wash_done) begin
        m_phase <= 0;
        m_rem   <= 0;
      end else if (state_time) begin
        m_phase <= next_phase(m_phase, double_time);
        m_rem   <= dur_tab[next_phase(m_phase, double_time)] * T;
      end else if (m_phase != 0 && m_rem > 0 && !pause) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_fin <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk_fsm) begin
    if (cmp_en) begin
      check("model_phase", int'(phase), m_phase);
      check("model_min_left", int'(min_left), (m_rem + T - 1) / T);
      check("model_busy", int'(busy), int'(m_phase != 0));
      check("model_timer_finish", int'(timer_finish), int'(m_fin));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_st(input logic dbl);
    state_time  = 1'b1;
    double_time = dbl;
    @(negedge clk_fsm);
    state_time  = 1'b0;
    double_time = 1'b0;
  endtask

  task automatic pulse_done();
    wash_done = 1'b1;
    @(negedge clk_fsm);
    wash_done = 1'b0;
  endtask

  // Count edges from now until timer_finish is seen high (bounded).
  task automatic wait_finish(input string name, input int exp_edges);
    int k;
    k = 0;
    while (k < 40 && !timer_finish) begin
      @(negedge clk_fsm);
      k++;
    end
    check({name, "_edges"}, k, exp_edges);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int cnt;
    repeat (2) @(negedge clk_fsm);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    check("rst_phase", int'(phase), 0);
    check("rst_min_left", int'(min_left), 0);
    check("rst_finish", int'(timer_finish), 0);
    check("rst_busy", int'(busy), 0);
    repeat (3) @(negedge clk_fsm);
    check("idle_hold_phase", int'(phase), 0);

    // Single FILL phase: finish rises at E0+4 for one cycle.
    pulse_st(1'b0);
    check("fill_phase", int'(phase), 1);
    check("fill_min_left", int'(min_left), 1);
    check("fill_busy", int'(busy), 1);
    wait_finish("fill", FILL * T);
    @(negedge clk_fsm);
    check("fill_pulse_width", int'(timer_finish), 0);

    // Full cycle, next phase loaded in the finish cycle.
    pulse_st(1'b0);
    check("wash_phase", int'(phase), 2);
    check("wash_min_left", int'(min_left), 2);
    wait_finish("wash", WASH * T);
    pulse_st(1'b1);  // double_time ignored outside RINSE
    check("rinse_phase", int'(phase), 3);
    check("rinse_min_left", int'(min_left), 1);
    wait_finish("rinse", RINSE * T);
    pulse_st(1'b0);
    check("spin_phase", int'(phase), 4);
    wait_finish("spin", SPIN * T);
    repeat (3) @(negedge clk_fsm);
    check("spin_hold_finish", int'(timer_finish), 0);
    check("spin_hold_min", int'(min_left), 0);
    check("spin_hold_phase", int'(phase), 4);
    pulse_done();
    check("done_phase", int'(phase), 0);
    check("done_busy", int'(busy), 0);
    check("done_min_left", int'(min_left), 0);

    // Double wash: RINSE expiry with double_time returns to WASH.
    pulse_st(1'b0);
    wait_finish("d_fill", FILL * T);
    pulse_st(1'b0);
    wait_finish("d_wash", WASH * T);
    pulse_st(1'b0);
    wait_finish("d_rinse", RINSE * T);
    pulse_st(1'b1);
    check("double_phase", int'(phase), 2);
    check("double_min_left", int'(min_left), 2);
    wait_finish("double_wash", WASH * T);

    // Asynchronous reset mid-WASH with one minute left.
    pulse_done();
    pulse_st(1'b0);
    pulse_st(1'b0);
    repeat (4) @(negedge clk_fsm);
    check("pre_rst_min_left", int'(min_left), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_phase", int'(phase), 0);
    check("async_rst_min_left", int'(min_left), 0);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_finish", int'(timer_finish), 0);
    @(negedge clk_fsm);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_fsm);
      if (timer_finish) cnt++;
    end
    check("post_rst_finish_count", cnt, 0);

    // Back-to-back advances restart mid-count; SPIN reloads itself.
    repeat (4) pulse_st(1'b0);
    check("b2b_phase", int'(phase), 4);
    check("b2b_min_left", int'(min_left), 1);
    repeat (2) @(negedge clk_fsm);
    pulse_st(1'b0);
    check("spin_reload_phase", int'(phase), 4);
    wait_finish("spin_reload", SPIN * T);

    // wash_done beats a simultaneous state_time in SPIN.
    state_time = 1'b1;
    wash_done  = 1'b1;
    @(negedge clk_fsm);
    state_time = 1'b0;
    wash_done  = 1'b0;
    check("st_wd_phase", int'(phase), 0);
    check("st_wd_min_left", int'(min_left), 0);
    check("st_wd_finish", int'(timer_finish), 0);

`ifdef WASH_TIMER_PAUSE_EN
    // Three paused cycles in FILL push expiry from E0+4 to E0+7.
    pulse_st(1'b0);
    pause = 1'b1;
    repeat (3) @(negedge clk_fsm);
    check("pause_fill_min", int'(min_left), 1);
    check("pause_fill_finish", int'(timer_finish), 0);
    pause = 1'b0;
    wait_finish("pause_fill_rest", FILL * T);
    // A load during pause holds at the loaded value.
    pause = 1'b1;
    pulse_st(1'b0);
    repeat (3) @(negedge clk_fsm);
    check("pause_load_phase", int'(phase), 2);
    check("pause_load_min", int'(min_left), 2);
    pause = 1'b0;
    wait_finish("pause_load", WASH * T);
`endif

    repeat (2) @(negedge clk_fsm);
    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
